// File: rtl/vdp_vram_arb.sv
// VDP VRAM arbiter: shares one synchronous-read VRAM between the video fetch engine
// and the CPU data port. Every grant takes two pxclk cycles: address phase, then data phase.
module vdp_vram_arb #(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic          pxclk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_addr_ld,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd_mode,
  input  logic          cpu_wr_stb,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_rd_stb,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_busy,
  output logic          cpu_ovf,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, VID_A, VID_B, CPU_RA, CPU_RB, CPU_WA, CPU_WB
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] addr_q;
  logic          pend;
  logic          pend_wr;
  logic [DW-1:0] wbuf;
  logic [CW-1:0] starve;
  logic          discard;

  logic          in_cpu;
  logic          cpu_b;
  logic          pend_eff;
  logic          cpu_win;
  logic          accept_wr;
  logic          accept_rd;
  logic          ovf;

  assign in_cpu   = (state == CPU_RA) || (state == CPU_RB) ||
                    (state == CPU_WA) || (state == CPU_WB);
  assign cpu_b    = (state == CPU_RB) || (state == CPU_WB);
  assign cpu_busy = pend | in_cpu;
  assign vid_data = vid_ack ? mem_rdata : '0;

  // An address load in the same cycle cancels a not-yet-granted op, so it may not win a slot.
  assign pend_eff  = pend & ~cpu_addr_ld;
  assign accept_wr = cpu_wr_stb & ~cpu_busy & ~cpu_addr_ld;
  assign accept_rd = cpu_rd_stb & ~cpu_wr_stb & ~cpu_busy & ~cpu_addr_ld;
  assign ovf       = (cpu_wr_stb & ~accept_wr) | (cpu_rd_stb & ~accept_rd);

  always_comb begin
    nxt     = state;
    cpu_win = 1'b0;
    case (state)
      VID_A:  nxt = VID_B;
      CPU_RA: nxt = CPU_RB;
      CPU_WA: nxt = CPU_WB;
      default: begin
        if (pend_eff && (starve == CW'(STARVE_MAX))) cpu_win = 1'b1;
        else if (vid_req)                            nxt     = VID_A;
        else if (pend_eff)                           cpu_win = 1'b1;
        else                                         nxt     = IDLE;
        if (cpu_win) nxt = pend_wr ? CPU_WA : CPU_RA;
      end
    endcase
  end

  always_ff @(posedge pxclk) begin
    if (accept_wr) wbuf <= cpu_wdata;
  end

  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      pend      <= 1'b0;
      pend_wr   <= 1'b0;
      starve    <= '0;
      discard   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      vid_ack   <= 1'b0;
      cpu_rdata <= '0;
      cpu_ovf   <= 1'b0;
    end else begin
      state   <= nxt;
      vid_ack <= (nxt == VID_B);
      cpu_ovf <= ovf;

      // Phase-A drive of the VRAM port; mem_we only ever spans one cycle.
      mem_we <= 1'b0;
      case (nxt)
        VID_A:  mem_addr <= vid_addr;
        CPU_RA: mem_addr <= addr_q;
        CPU_WA: begin
          mem_addr  <= addr_q;
          mem_we    <= 1'b1;
          mem_wdata <= wbuf;
        end
        default: ;
      endcase

      if (state == CPU_RB) cpu_rdata <= mem_rdata;

      // A reload during an in-flight op wins over that op's post-increment.
      if (cpu_addr_ld)            addr_q <= cpu_addr;
      else if (cpu_b && !discard) addr_q <= addr_q + 1'b1;

      if (cpu_addr_ld && ((state == CPU_RA) || (state == CPU_WA))) discard <= 1'b1;
      else if (cpu_b)                                              discard <= 1'b0;

      if (cpu_addr_ld) begin
        pend    <= cpu_rd_mode;
        pend_wr <= 1'b0;
      end else if (cpu_win) begin
        pend    <= 1'b0;
      end else if (accept_wr) begin
        pend    <= 1'b1;
        pend_wr <= 1'b1;
      end else if (accept_rd) begin
        pend    <= 1'b1;
        pend_wr <= 1'b0;
      end

      if (cpu_addr_ld || cpu_win)                  starve <= '0;
      else if (pend && (starve != CW'(STARVE_MAX))) starve <= starve + 1'b1;
    end
  end

endmodule
